// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment bus, decodes each digit back to BCD and
// publishes complete frames once they have been stable for STABLE_FRAMES scans.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  overflow
);

    localparam int CW = $clog2(STABLE_FRAMES + 1);

    typedef enum logic {
        COLLECT = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t                state;
    logic [4*DIGITS-1:0]   slot_bcd, buf_bcd, prev_bcd, pub_bcd;
    logic [DIGITS-1:0]     slot_err, buf_err, prev_err, pub_err, seen;
    logic [CW-1:0]         stable_cnt;
    logic                  has_pub;

    logic                  onehot, accept, complete;
    logic [3:0]            dec_nib;
    logic                  dec_err;
    logic [4*DIGITS-1:0]   samp_bcd;
    logic [DIGITS-1:0]     samp_err;
    logic [CW-1:0]         new_cnt;
    logic                  same_prev, publish;

    always_comb begin
        dec_err = 1'b0;
        case (seg_in)
            7'b1111110: dec_nib = 4'h0;
            7'b0110000: dec_nib = 4'h1;
            7'b1101101: dec_nib = 4'h2;
            7'b1111001: dec_nib = 4'h3;
            7'b0110011: dec_nib = 4'h4;
            7'b1011011: dec_nib = 4'h5;
            7'b1011111: dec_nib = 4'h6;
            7'b1110000: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1111011: dec_nib = 4'h9;
            7'b0000000: dec_nib = 4'hA;
            default: begin
                dec_nib = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        onehot   = (an_in != '0) && ((an_in & (an_in - DIGITS'(1))) == '0);
        accept   = sample_en && onehot;
        complete = accept && ((seen | an_in) == '1);
        samp_bcd = slot_bcd;
        samp_err = slot_err;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (an_in[i]) begin
                samp_bcd[4*i +: 4] = dec_nib;
                samp_err[i]        = dec_err;
            end
        end
    end

    // First frame after reset (count 0) always starts the run at 1.
    always_comb begin
        same_prev = ({buf_bcd, buf_err} == {prev_bcd, prev_err});
        if (stable_cnt == '0 || !same_prev)
            new_cnt = CW'(1);
        else if (stable_cnt == CW'(STABLE_FRAMES))
            new_cnt = stable_cnt;
        else
            new_cnt = stable_cnt + CW'(1);
        publish = (new_cnt == CW'(STABLE_FRAMES)) &&
                  (!has_pub || ({buf_bcd, buf_err} != {pub_bcd, pub_err}));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            slot_bcd   <= '0;
            slot_err   <= '0;
            seen       <= '0;
            buf_bcd    <= '0;
            buf_err    <= '0;
            prev_bcd   <= '0;
            prev_err   <= '0;
            pub_bcd    <= '0;
            pub_err    <= '0;
            stable_cnt <= '0;
            has_pub    <= 1'b0;
            out_valid  <= 1'b0;
            bcd_out    <= '0;
            err_out    <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= COLLECT;
            if (accept) begin
                slot_bcd <= samp_bcd;
                slot_err <= samp_err;
                if (complete) begin
                    buf_bcd <= samp_bcd;
                    buf_err <= samp_err;
                    seen    <= '0;
                    state   <= COMPARE;
                end else begin
                    seen <= seen | an_in;
                end
            end

            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (state == COMPARE) begin
                stable_cnt <= new_cnt;
                prev_bcd   <= buf_bcd;
                prev_err   <= buf_err;
                if (publish) begin
                    // A dropped frame leaves the reference alone so it re-publishes later.
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        bcd_out   <= buf_bcd;
                        err_out   <= buf_err;
                        pub_bcd   <= buf_bcd;
                        pub_err   <= buf_err;
                        has_pub   <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the team's BCD-to-7-segment encoder. It samples a multiplexed multi-digit 7-segment bus (segment pattern plus one-hot digit strobe) and decodes each pattern back to BCD. It assembles full frames, requires a frame to be stable for a set number of scans, then publishes it on a valid/ready output. It sits between a display-bus snoop or loopback and the checking/processor logic.

Parameters:
DIGITS, 4, number of multiplexed digits; width of the strobe and error vectors.
STABLE_FRAMES, 2, consecutive identical frames required before a frame is published (>=1).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
sample_en  input  1  seg_in/an_in are valid this cycle
seg_in  input  7  segment pattern, active-high, bit6=a ... bit0=g
an_in  input  DIGITS  digit strobe, active-high, must be one-hot to be accepted
out_valid  output  1  published frame available
out_ready  input  1  consumer accepts the frame
bcd_out  output  4*DIGITS  decoded frame; digit i in bits [4i+3:4i]
err_out  output  DIGITS  per-digit illegal-pattern flag, published with bcd_out
overflow  output  1  sticky: a publishable frame was dropped

Behaviour:
- Reset is synchronous; all state clears when rst_n=0 at a clock edge. Reset values: out_valid=0, bcd_out=0, err_out=0, overflow=0. Internal state also clears: seen mask=0, stable count=0, "has published" flag=0. Reset mid-frame discards any partial frame.
- Decode table, per pattern:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - 0000000 (blank) = 4'hA, err=0.
  - Any other pattern = 4'hF, err=1.
- Sampling: an edge with sample_en=1 and an_in one-hot at bit i writes the decoded nibble and err bit into slot i and sets seen[i].
  - If an_in is zero or multi-hot, the cycle is ignored.
  - A repeat of an already-seen digit overwrites its slot; the frame does not complete.
- Frame completion: on the edge that sets the last missing seen bit, the completed slots (including the new digit) are copied to frame_buf, seen clears, and frame_done is registered high for one cycle.
  - A sample in the very next cycle starts a new frame normally.
- Stability: on the edge where frame_done=1, frame_buf is compared with the previous completed frame.
  - Equal: stable count increments, saturating at STABLE_FRAMES.
  - Different: count resets to 1.
  - The first frame after reset counts as 1.
- Publish condition, evaluated on that same edge: count reaches STABLE_FRAMES, AND (has published=0 OR frame_buf differs from the last published frame).
  - An unchanged stable frame publishes only once.
- Latency: out_valid rises one cycle after frame_done, i.e. two edges after the final digit sample.
- Output handshake:
  - out_valid, bcd_out and err_out hold until out_valid && out_ready at an edge. That edge clears out_valid unless a publish occurs on the same edge.
  - Publish with out_valid=0, or with out_valid=1 and out_ready=1: load the new frame, out_valid=1, no overflow.
  - Publish with out_valid=1 and out_ready=0: the new frame is dropped, output is unchanged, overflow is set. The last-published reference is not updated, so the dropped frame re-publishes once it is stable and the output is free.
- overflow clears only on reset.
- Comparisons use both nibbles and err bits.
- Control FSM:
  - COLLECT: accumulate digits; frame completion moves to COMPARE.
  - COMPARE: one cycle; stability/publish update; returns to COLLECT.
  - Sampling continues in COMPARE, so the FSM never stalls the bus.

Test Plan:
1. Hold rst_n=0 for 2 edges mid-activity -> out_valid=0, bcd_out=16'h0000, err_out=0, overflow=0. Send a partial frame (digits 0,1), reset, then a full frame -> publish only after 2 full post-reset frames.
2. Two scans of digits 0..3 = patterns for 1,2,3,4 -> out_valid rises 2 edges after the last sample of scan 2, bcd_out=16'h4321, err_out=4'b0000. A third identical scan -> no new out_valid.
3. Digit 2 = 0000001 and digit 3 = 0000000 for two scans, digits 0,1 = 5 -> bcd_out=16'hAF55, err_out=4'b0100.
4. out_ready=0; publish 16'h1111, then two scans of 16'h2222 -> bcd_out stays 16'h1111, overflow=1. Raise out_ready -> next stable 2222 scan publishes 16'h2222.
5. an_in=4'b0011 or 4'b0000 with sample_en=1 -> no slot written, no frame completion. Repeat digit 1 twice within a scan -> the last value wins.
6. Scans alternating 16'h1234 / 16'h1235 -> count never reaches 2, out_valid stays 0.
